// File: rtl/mips_sign_extension.sv
// ---------------------------------------------------------------------------
// mips_sign_extension
//
// Immediate-extension unit for the MIPS datapath. It sits between the decoded
// instruction field instr[15:0] and the ALU B-operand / branch adder.
//
// Two paths:
//   * signed_offset : combinational 32-bit sign extension of offset. It does
//                     not depend on the clock, reset or the mode/valid inputs.
//   * ext_out       : registered, mode-selected extension with one cycle of
//                     latency. ext_valid marks a result that was captured on
//                     the previous edge. ext_neg is a registered copy of
//                     ext_out[31].
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous reset, active low
//   offset        in  16   immediate field instr[15:0]
//   signed_offset out 32   combinational sign extension of offset
//   ext_mode      in   3   extension select for the registered path
//   in_valid      in   1   offset/ext_mode carry a new request this cycle
//   ext_out       out 32   registered extension result
//   ext_valid     out  1   ext_out was updated on the previous edge
//   ext_neg       out  1   registered sign bit of ext_out
//
// Mode encoding:
//   0 SEXT16, 1 ZEXT16, 2 LUI, 3 BRANCH (SEXT16 << 2), 4 SEXT8, 5 ZEXT8.
//   Modes 6 and 7 are reserved and decode as SEXT16.
// ---------------------------------------------------------------------------
module mips_sign_extension (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] offset,
    output logic [31:0] signed_offset,
    input  logic [2:0]  ext_mode,
    input  logic        in_valid,
    output logic [31:0] ext_out,
    output logic        ext_valid,
    output logic        ext_neg
);

    typedef enum logic [2:0] {
        MODE_SEXT16 = 3'd0,
        MODE_ZEXT16 = 3'd1,
        MODE_LUI    = 3'd2,
        MODE_BRANCH = 3'd3,
        MODE_SEXT8  = 3'd4,
        MODE_ZEXT8  = 3'd5
    } ext_mode_e;

    // Builds the mode-selected 32-bit result. The BRANCH form keeps only
    // 14 copies of the sign bit, so the two bits shifted past bit 31 are
    // simply discarded.
    function automatic logic signed [31:0] extend_imm(
        input logic [15:0] imm,
        input logic [2:0]  mode
    );
        logic signed [31:0] res;
        case (mode)
            MODE_ZEXT16: res = $signed({16'h0000, imm});
            MODE_LUI:    res = $signed({imm, 16'h0000});
            MODE_BRANCH: res = $signed({{14{imm[15]}}, imm, 2'b00});
            MODE_SEXT8:  res = $signed({{24{imm[7]}}, imm[7:0]});
            MODE_ZEXT8:  res = $signed({24'h000000, imm[7:0]});
            default:     res = $signed({{16{imm[15]}}, imm});
        endcase
        return res;
    endfunction

    // Combinational path: pure function of offset only.
    assign signed_offset = {{16{offset[15]}}, offset};

    // ---- stage p0: decode the request ----
    logic signed [31:0] ext_res_p0;
    logic               vld_p0;

    always_comb begin
        ext_res_p0 = extend_imm(offset, ext_mode);
        vld_p0     = in_valid;
    end

    // ---- stage p1: result register ----
    // The result register is also cleared by reset because the interface
    // requires ext_out and ext_neg to read zero after reset. Data holds when
    // no request is present; only the valid flag drops.
    logic signed [31:0] ext_out_p1;
    logic               ext_neg_p1;
    logic               vld_p1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_out_p1 <= '0;
            ext_neg_p1 <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                ext_out_p1 <= ext_res_p0;
                ext_neg_p1 <= ext_res_p0[31];
            end
        end
    end

    assign ext_out   = ext_out_p1;
    assign ext_neg   = ext_neg_p1;
    assign ext_valid = vld_p1;

endmodule

// File: tb/tb_mips_sign_extension.sv
module tb_mips_sign_extension;

    logic        clk;
    logic        rst;
    logic [15:0] offset;
    logic [31:0] signed_offset;
    logic [2:0]  ext_mode;
    logic        in_valid;
    logic [31:0] ext_out;
    logic        ext_valid;
    logic        ext_neg;

    mips_sign_extension dut (
        .clk           (clk),
        .rst           (rst),
        .offset        (offset),
        .signed_offset (signed_offset),
        .ext_mode      (ext_mode),
        .in_valid      (in_valid),
        .ext_out       (ext_out),
        .ext_valid     (ext_valid),
        .ext_neg       (ext_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] out;
        logic        neg;
        logic        vld;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_out;
    logic        mdl_neg;
    int          n_tests;
    int          n_fail;

    localparam logic [15:0] SO_IN  [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE};
    localparam logic [31:0] SO_EXP [6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00007FFF,
                                           32'hFFFF8000, 32'h00000001, 32'hFFFFFFFE};
    localparam logic [31:0] B2B_OUT [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};
    localparam logic        B2B_NEG [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reference model built from arithmetic on signed quantities.
    function automatic logic [31:0] ref_ext(input logic [15:0] off, input logic [2:0] mode);
        logic signed [15:0] s16;
        logic signed [7:0]  s8;
        logic signed [31:0] w16;
        logic signed [31:0] w8;
        s16 = off;
        s8  = off[7:0];
        w16 = s16;
        w8  = s8;
        case (mode)
            3'd1:    return 32'(off);
            3'd2:    return 32'(off) * 32'd65536;
            3'd3:    return w16 * 4;
            3'd4:    return w8;
            3'd5:    return 32'(off[7:0]);
            default: return w16;
        endcase
    endfunction

    // Drive one cycle of stimulus, push the expected registered outputs,
    // then advance to just after the edge.
    task automatic cycle(input logic v, input logic [15:0] off, input logic [2:0] mode, input logic r);
        exp_t e;
        rst      = r;
        in_valid = v;
        offset   = off;
        ext_mode = mode;
        if (!r) begin
            mdl_out = 32'h0;
            mdl_neg = 1'b0;
            e.vld   = 1'b0;
        end else begin
            if (v) begin
                mdl_out = ref_ext(off, mode);
                mdl_neg = mdl_out[31];
            end
            e.vld = v;
        end
        e.out = mdl_out;
        e.neg = mdl_neg;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed_offset();
        // Control inputs unknown and reset asserted: the combinational path
        // must not care.
        rst      = 1'b0;
        in_valid = 1'bx;
        ext_mode = 3'bxxx;
        for (int i = 0; i < 6; i++) begin
            offset = SO_IN[i];
            #3;
            n_tests++;
            if (signed_offset !== SO_EXP[i]) begin
                n_fail++;
                $display("FAIL signed_offset[%0d] off=%h got=%h want=%h", i, SO_IN[i], signed_offset, SO_EXP[i]);
            end
        end
        in_valid = 1'b0;
        ext_mode = 3'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 16'hFFFF, 3'd3, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (ext_out !== 32'h0 || ext_neg !== 1'b0 || ext_valid !== 1'b0 ||
                ext_out !== e.out || ext_valid !== e.vld) begin
                n_fail++;
                $display("FAIL reset[%0d] got out=%h neg=%b vld=%b want out=00000000 neg=0 vld=0",
                         i, ext_out, ext_neg, ext_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h8001, 3'(i), 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (ext_out !== e.out || ext_neg !== e.neg || ext_valid !== e.vld) begin
                n_fail++;
                $display("FAIL b2b_sb[%0d] got out=%h neg=%b vld=%b want out=%h neg=%b vld=%b",
                         i, ext_out, ext_neg, ext_valid, e.out, e.neg, e.vld);
            end
            n_tests++;
            if (ext_out !== B2B_OUT[i] || ext_neg !== B2B_NEG[i] || ext_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_const[%0d] got out=%h neg=%b vld=%b want out=%h neg=%b vld=1",
                         i, ext_out, ext_neg, ext_valid, B2B_OUT[i], B2B_NEG[i]);
            end
        end
    endtask

    task automatic test_modes();
        exp_t        e;
        logic [15:0] offs [4] = '{16'h1280, 16'h1280, 16'h8000, 16'h7FFF};
        logic [2:0]  mods [4] = '{3'd4, 3'd5, 3'd7, 3'd6};
        logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00007FFF};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, offs[i], mods[i], 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (ext_out !== want[i] || ext_out !== e.out || ext_neg !== e.neg || ext_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL mode%0d got out=%h neg=%b vld=%b want out=%h neg=%b vld=1",
                         mods[i], ext_out, ext_neg, ext_valid, want[i], e.neg);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        cycle(1'b1, 16'h1234, 3'd2, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (ext_out !== 32'h12340000 || ext_valid !== 1'b1 || ext_out !== e.out) begin
            n_fail++;
            $display("FAIL hold_load got out=%h vld=%b want out=12340000 vld=1", ext_out, ext_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 16'hAAAA, 3'd1, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (ext_out !== 32'h12340000 || ext_neg !== 1'b0 || ext_valid !== 1'b0 ||
                ext_out !== e.out || ext_valid !== e.vld) begin
                n_fail++;
                $display("FAIL hold_idle[%0d] got out=%h neg=%b vld=%b want out=12340000 neg=0 vld=0",
                         i, ext_out, ext_neg, ext_valid);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        exp_t e;
        cycle(1'b1, 16'h8000, 3'd0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (ext_out !== 32'hFFFF8000 || ext_neg !== 1'b1 || ext_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got out=%h neg=%b vld=%b want out=ffff8000 neg=1 vld=1",
                     ext_out, ext_neg, ext_valid);
        end
        rst = 1'b0; in_valid = 1'b1; offset = 16'hFFFF;
        #1;
        n_tests++;
        if (signed_offset !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL midrst_so_before got=%h want=ffffffff", signed_offset);
        end
        cycle(1'b1, 16'hFFFF, 3'd0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (ext_out !== 32'h0 || ext_neg !== 1'b0 || ext_valid !== 1'b0 || ext_out !== e.out) begin
            n_fail++;
            $display("FAIL midrst got out=%h neg=%b vld=%b want out=00000000 neg=0 vld=0",
                     ext_out, ext_neg, ext_valid);
        end
        n_tests++;
        if (signed_offset !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL midrst_so_after got=%h want=ffffffff", signed_offset);
        end
        cycle(1'b0, 16'hFFFF, 3'd0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (ext_out !== 32'h0 || ext_valid !== 1'b0 || ext_neg !== 1'b0 || ext_valid !== e.vld) begin
            n_fail++;
            $display("FAIL midrst_post got out=%h neg=%b vld=%b want out=00000000 neg=0 vld=0",
                     ext_out, ext_neg, ext_valid);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [15:0] off;
        logic [31:0] so_exp;
        logic signed [15:0] s;
        for (int i = 0; i < 60; i++) begin
            off = 16'($urandom);
            cycle(($urandom_range(0, 3) != 0), off, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) != 0));
            e = sb.pop_front();
            n_tests++;
            if (ext_out !== e.out || ext_neg !== e.neg || ext_valid !== e.vld) begin
                n_fail++;
                $display("FAIL rand[%0d] got out=%h neg=%b vld=%b want out=%h neg=%b vld=%b",
                         i, ext_out, ext_neg, ext_valid, e.out, e.neg, e.vld);
            end
            s      = off;
            so_exp = 32'(s);
            n_tests++;
            if (signed_offset !== so_exp) begin
                n_fail++;
                $display("FAIL rand_so[%0d] got=%h want=%h", i, signed_offset, so_exp);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        mdl_out  = 32'h0;
        mdl_neg  = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        offset   = 16'h0;
        ext_mode = 3'd0;

        test_signed_offset();
        test_reset();
        test_back_to_back();
        test_modes();
        test_hold();
        test_reset_mid_stream();
        test_random();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
